// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed driver for a common-anode seven-segment display.
//
// A prescaler divides clk into digit slots of PRESCALE cycles. At each slot boundary
// ("tick") the next digit is selected and its segment pattern is registered, so sel and
// seg change together and hold steady for a whole slot.
//
// Parameters
//   DIGITS   number of scanned digits (1..SEL_W)
//   SEL_W    width of the digit-select bus
//   PRESCALE clk cycles per digit slot (>= 1)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low blanks the display and restarts the scan
//   digits_in   one hex nibble per digit, digit 0 in bits [3:0]
//   blank_mask  bit i forces digit i dark (dp still honoured)
//   dp_mask     bit i lights the decimal point of digit i
//   sel         active-low digit select, at most one bit low
//   seg         active-low segments, seg[7]=dp, seg[6:0]=g..a
//   frame_done  one-cycle pulse when the last digit has just been selected
//
// Build option
//   DIGIT_SCAN_LZB_EN  when defined, leading zeros (digits above 0 whose nibble and all
//                      higher nibbles are zero) are blanked.

module digit_scan_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SEL_W    = 8,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [SEL_W-1:0]      sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PtrW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(PRESCALE - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DIGITS - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  ptr_q, ptr_d, ptr_next;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic             fd_q, fd_d;
  logic             tick;
  logic [3:0]       nib;
  logic             dark;
  logic             dp;

  // Active-low g..a patterns for hex digits 0..F.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

`ifdef DIGIT_SCAN_LZB_EN
  // Digit idx is a leading zero when it and every nibble above it are zero.
  // Digit 0 always shows, so a value of zero still displays "0".
  function automatic logic lead_zero(input logic [4*DIGITS-1:0] d, input int unsigned idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (j >= idx && d[4*j +: 4] != 4'h0) all_zero = 1'b0;
    end
    return (idx != 0) && all_zero;
  endfunction
`endif

  always_comb begin
    tick     = en && (cnt_q == CntMax);
    ptr_next = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;

    // Select the fields of the digit about to be shown.
    nib  = '0;
    dark = 1'b0;
    dp   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (ptr_next == PtrW'(i)) begin
        nib  = digits_in[4*i +: 4];
        dp   = dp_mask[i];
`ifdef DIGIT_SCAN_LZB_EN
        dark = blank_mask[i] | lead_zero(digits_in, i);
`else
        dark = blank_mask[i];
`endif
      end
    end

    cnt_d = cnt_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    seg_d = seg_q;
    fd_d  = 1'b0;

    if (!en) begin
      // Parking ptr on the last digit makes the first tick land on digit 0.
      cnt_d = '0;
      ptr_d = PtrLast;
      sel_d = '1;
      seg_d = 8'hFF;
    end else if (tick) begin
      cnt_d = '0;
      ptr_d = ptr_next;
      sel_d = ~(SEL_W'(1) << ptr_next);
      seg_d = {~dp, dark ? 7'h7F : decode(nib)};
      fd_d  = (ptr_next == PtrLast);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= PtrLast;
      sel_q <= '1;
      seg_q <= 8'hFF;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      fd_q  <= fd_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule
